// File: rtl/stream_pack_arbiter_pkg.sv
// Shared types and constants for the stream pack arbiter.
// Holds the arbiter state enum and the byte-count field width.
package stream_pack_arbiter_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int CNT_W = 32;

endpackage

// File: rtl/stream_pack_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set request bit
// at or after 'base', wrapping around, plus whether any bit is set.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [IW-1:0] idx,
  output logic          any
);

  int cand;

  // Scan from the far end back toward base so the closest match wins last.
  always_comb begin
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = int'(base) + k;
      if (cand >= N) cand = cand - N;
      if (req[cand[IW-1:0]]) begin
        idx = cand[IW-1:0];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_pack_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_REQ beat streams into one
// registered output stream; the grant is held for a whole packet.
module stream_pack_arbiter
  import stream_pack_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int NUM_BYTES = 64,
  localparam int IW        = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ*NUM_BYTES*8-1:0] s_data,
  input  logic [NUM_REQ-1:0]             s_valid,
  input  logic [NUM_REQ-1:0]             s_last,
  input  logic [NUM_REQ*CNT_W-1:0]       s_num_bytes_valid,
  output logic [NUM_REQ-1:0]             s_ready,
  output logic [NUM_BYTES*8-1:0]         m_data,
  output logic                           m_valid,
  output logic                           m_last,
  output logic [CNT_W-1:0]               m_num_bytes_valid,
  input  logic                           m_ready,
  output logic [IW-1:0]                  m_src,
  output logic [CNT_W-1:0]               pkt_count,
  output logic                           err_oversize,
  output state_e                         dbg_state
);

  localparam int DW = NUM_BYTES * 8;

  // Handshakes: a beat moves on an edge where valid and ready are both high;
  // valid never waits on ready, and the m_ beat holds while m_valid & ~m_ready.
  state_e           state_q, state_d;
  logic [IW-1:0]    gnt_q, gnt_d, lst_q, lst_d, base;
  logic [DW-1:0]    m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d, m_last_q, m_last_d;
  logic [CNT_W-1:0] m_nbv_q, m_nbv_d, pkt_count_q, pkt_count_d;
  logic [IW-1:0]    m_src_q, m_src_d;
  logic             err_q, err_d;
  logic             pick_any, accept, oversize;
  logic [IW-1:0]    pick_idx;
  logic [CNT_W-1:0] beat_nbv;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_pick (
    .req  (s_valid),
    .base (base),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    base     = (lst_q == IW'(NUM_REQ - 1)) ? '0 : lst_q + IW'(1);
    s_ready  = '0;
    if (state_q == STREAM) s_ready[gnt_q] = ~m_valid_q | m_ready;
    accept   = (state_q == STREAM) && s_valid[gnt_q] && s_ready[gnt_q];
    beat_nbv = s_num_bytes_valid[int'(gnt_q)*CNT_W +: CNT_W];
    oversize = beat_nbv > CNT_W'(NUM_BYTES);
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lst_d       = lst_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    m_last_d    = m_last_q;
    m_nbv_d     = m_nbv_q;
    m_src_d     = m_src_q;
    pkt_count_d = pkt_count_q;
    err_d       = err_q;
    if (accept) begin
      m_data_d  = s_data[int'(gnt_q)*DW +: DW];
      m_last_d  = s_last[gnt_q];
      m_nbv_d   = oversize ? CNT_W'(NUM_BYTES) : beat_nbv;
      m_src_d   = gnt_q;
      m_valid_d = 1'b1;
      err_d     = err_q | oversize;
      if (s_last[gnt_q]) begin
        state_d     = IDLE;
        lst_d       = gnt_q;
        pkt_count_d = pkt_count_q + CNT_W'(1);
      end
    end else if (m_ready) begin
      m_valid_d = 1'b0;
    end
    // Arbitration costs one cycle; s_ready stays low while in IDLE.
    if (state_q == IDLE && pick_any) begin
      gnt_d   = pick_idx;
      state_d = STREAM;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      lst_q       <= IW'(NUM_REQ - 1);
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_nbv_q     <= '0;
      m_src_q     <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lst_q       <= lst_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_nbv_q     <= m_nbv_d;
      m_src_q     <= m_src_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

  assign m_data            = m_data_q;
  assign m_valid           = m_valid_q;
  assign m_last            = m_last_q;
  assign m_num_bytes_valid = m_nbv_q;
  assign m_src             = m_src_q;
  assign pkt_count         = pkt_count_q;
  assign err_oversize      = err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_stream_pack_arbiter.sv
// Bench for stream_pack_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural packet-arbitration model.
module tb_stream_pack_arbiter;
  import stream_pack_arbiter_pkg::*;

  localparam int NR = 4;
  localparam int NB = 64;
  localparam int DW = NB * 8;
  localparam int SW = 66;

  logic              clk, rst;
  logic [NR*DW-1:0]  s_data;
  logic [NR-1:0]     s_valid, s_last, s_ready;
  logic [NR*32-1:0]  s_num_bytes_valid;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_last, m_ready, err_oversize;
  logic [31:0]       m_num_bytes_valid, pkt_count;
  logic [1:0]        m_src;
  state_e            dbg_state;

  stream_pack_arbiter #(.NUM_REQ(NR), .NUM_BYTES(NB)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_num_bytes_valid(s_num_bytes_valid), .s_ready(s_ready), .m_data(m_data),
    .m_valid(m_valid), .m_last(m_last), .m_num_bytes_valid(m_num_bytes_valid),
    .m_ready(m_ready), .m_src(m_src), .pkt_count(pkt_count),
    .err_oversize(err_oversize), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- source queues and control ----------------
  logic [DW-1:0] sm_data[NR][64];
  logic [31:0]   sm_nbv[NR][64];
  logic          sm_last[NR][64];
  int            head[NR], tail[NR];
  logic [NR-1:0] gate;
  bit            gate_rand, mr_rand, mr_level;
  int            cyc;

  // ---------------- scoreboard / log ----------------
  logic [SW-1:0] exp_q[$];
  int            n_checks, n_pass;
  int            out_n;
  int            out_src[32], out_last[32], out_nbv[32], out_cyc[32];

  // ---------------- behavioural model ----------------
  bit            mdl_busy, mdl_mv, mdl_last, mdl_err;
  int            mdl_own, mdl_lst, mdl_src;
  logic [DW-1:0] mdl_data;
  logic [31:0]   mdl_nbv, mdl_pkts;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    mdl_busy = 0; mdl_mv = 0; mdl_last = 0; mdl_err = 0;
    mdl_own = 0; mdl_lst = NR - 1; mdl_src = 0;
    mdl_data = '0; mdl_nbv = '0; mdl_pkts = '0;
  endtask

  task automatic model_update(input logic [NR-1:0] rdy);
    bit was_busy;
    logic [31:0] nb;
    if (rst) begin
      model_reset();
      return;
    end
    was_busy = mdl_busy;
    if (mdl_busy && s_valid[mdl_own] && rdy[mdl_own]) begin
      nb       = s_num_bytes_valid[mdl_own*32 +: 32];
      mdl_data = s_data[mdl_own*DW +: DW];
      mdl_last = s_last[mdl_own];
      mdl_nbv  = (nb > NB) ? NB : nb;
      mdl_err  = mdl_err || (nb > NB);
      mdl_src  = mdl_own;
      mdl_mv   = 1;
      if (s_last[mdl_own]) begin
        mdl_busy = 0;
        mdl_lst  = mdl_own;
        mdl_pkts = mdl_pkts + 1;
      end
    end else if (m_ready) begin
      mdl_mv = 0;
    end
    if (!was_busy) begin
      for (int k = 1; k <= NR; k++) begin
        int c;
        c = (mdl_lst + k) % NR;
        if (!mdl_busy && s_valid[c]) begin
          mdl_own  = c;
          mdl_busy = 1;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic push_beat(input int r, input logic [31:0] nbv, input logic last);
    logic [DW-1:0] d;
    for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
    sm_data[r][tail[r] % 64] = d;
    sm_nbv[r][tail[r] % 64]  = nbv;
    sm_last[r][tail[r] % 64] = last;
    tail[r]++;
  endtask

  task automatic apply();
    for (int r = 0; r < NR; r++) begin
      if (gate_rand) gate[r] = ($urandom_range(0, 3) != 0);
      s_valid[r] = (head[r] < tail[r]) && gate[r] && !rst;
      s_data[r*DW +: DW] = (head[r] < tail[r]) ? sm_data[r][head[r] % 64] : '0;
      s_num_bytes_valid[r*32 +: 32] = (head[r] < tail[r]) ? sm_nbv[r][head[r] % 64] : '0;
      s_last[r] = (head[r] < tail[r]) ? sm_last[r][head[r] % 64] : 1'b0;
    end
    m_ready = mr_rand ? ($urandom_range(0, 3) != 0) : mr_level;
  endtask

  task automatic step();
    logic [NR-1:0] exp_rdy, acc_src;
    logic [SW-1:0] got;
    apply();
    #1;
    exp_rdy = '0;
    if (mdl_busy && (!mdl_mv || m_ready)) exp_rdy[mdl_own] = 1'b1;
    chk("s_ready", s_ready, exp_rdy);
    chk("m_valid", m_valid, mdl_mv);
    chk("pkt_count", pkt_count, mdl_pkts);
    chk("err_oversize", err_oversize, mdl_err);
    chk("dbg_state", dbg_state, mdl_busy);
    if (mdl_mv) begin
      chk("m_data", m_data, mdl_data);
      chk("m_last", m_last, mdl_last);
      chk("m_num_bytes_valid", m_num_bytes_valid, mdl_nbv);
      chk("m_src", m_src, mdl_src);
    end
    if (!rst && m_valid && m_ready) begin
      if (out_n < 32) begin
        out_src[out_n] = m_src; out_last[out_n] = m_last;
        out_nbv[out_n] = m_num_bytes_valid; out_cyc[out_n] = cyc;
      end
      out_n++;
      chk("sb_nonempty", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        got = {m_src, m_data[63:0]};
        chk("sb_beat", got, exp_q.pop_front());
      end
    end
    acc_src = s_valid & s_ready;
    for (int r = 0; r < NR; r++)
      if (acc_src[r] && !rst) exp_q.push_back({2'(r), sm_data[r][head[r] % 64][63:0]});
    model_update(exp_rdy);
    @(posedge clk);
    for (int r = 0; r < NR; r++) if (acc_src[r]) head[r]++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    gate = '0;
    step();
    rst = 1'b0;
    for (int r = 0; r < NR; r++) begin head[r] = 0; tail[r] = 0; end
    exp_q.delete();
    out_n = 0;
    apply();
    #1;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_nbv", m_num_bytes_valid, 0);
    chk("rst_m_src", m_src, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_err", err_oversize, 0);
    chk("rst_state", dbg_state, IDLE);
  endtask

  function automatic bit pending();
    bit p;
    p = mdl_mv || mdl_busy;
    for (int r = 0; r < NR; r++) if (head[r] < tail[r]) p = 1;
    return p;
  endfunction

  task automatic run_until_done(input int max);
    int n;
    n = 0;
    while (pending() && n < max) begin step(); n++; end
    chk("drain_in_time", n < max, 1);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int c0, guard;
    n_checks = 0; n_pass = 0; cyc = 0; out_n = 0;
    gate_rand = 0; mr_rand = 0; mr_level = 1; gate = '0;
    rst = 1'b1; m_ready = 1'b0; s_valid = '0; s_last = '0;
    s_data = '0; s_num_bytes_valid = '0;
    for (int r = 0; r < NR; r++) begin head[r] = 0; tail[r] = 0; end
    model_reset();
    @(negedge clk);

    // Single requester 1, three beats 64/64/10.
    do_reset();
    gate = '1;
    push_beat(1, 64, 0); push_beat(1, 64, 0); push_beat(1, 10, 1);
    c0 = cyc;
    run_until_done(50);
    chk("t1_beats", out_n, 3);
    for (int i = 0; i < 3; i++) chk("t1_src", out_src[i], 1);
    chk("t1_last0", out_last[0], 0);
    chk("t1_last1", out_last[1], 0);
    chk("t1_last2", out_last[2], 1);
    chk("t1_nbv2", out_nbv[2], 10);
    chk("t1_first_latency", out_cyc[0] - c0, 2);
    chk("t1_pkt_count", pkt_count, 1);

    // All four continuously valid with 1-beat packets.
    do_reset();
    gate = '1;
    for (int p = 0; p < 2; p++)
      for (int r = 0; r < NR; r++) push_beat(r, $urandom_range(0, 64), 1);
    run_until_done(100);
    chk("t2_beats", out_n, 8);
    chk("t2_g0", out_src[0], 0);
    chk("t2_g1", out_src[1], 1);
    chk("t2_g2", out_src[2], 2);
    chk("t2_g3", out_src[3], 3);
    chk("t2_g4", out_src[4], 0);
    chk("t2_pkt_count", pkt_count, 8);

    // Downstream stall of 5 cycles mid-packet.
    do_reset();
    gate = '1;
    push_beat(0, 11, 0); push_beat(0, 22, 0); push_beat(0, 33, 0); push_beat(0, 44, 1);
    guard = 0;
    while (out_n == 0 && guard < 20) begin step(); guard++; end
    chk("t3_first_out", out_n, 1);
    mr_level = 0;
    repeat (5) begin
      apply();
      #1;
      chk("t3_hold_valid", m_valid, 1);
      chk("t3_hold_nbv", m_num_bytes_valid, 22);
      chk("t3_hold_ready", s_ready, 0);
      step();
    end
    mr_level = 1;
    run_until_done(50);
    chk("t3_beats", out_n, 4);
    chk("t3_nbv1", out_nbv[1], 22);
    chk("t3_nbv2", out_nbv[2], 33);
    chk("t3_nbv3", out_nbv[3], 44);

    // Requester 2 drops valid mid-packet while requester 0 waits.
    do_reset();
    gate = '1;
    push_beat(2, 5, 0); push_beat(2, 6, 0); push_beat(2, 7, 0); push_beat(2, 8, 1);
    guard = 0;
    while (head[2] == 0 && guard < 20) begin step(); guard++; end
    chk("t4_started", head[2], 1);
    push_beat(0, 9, 1);
    gate[2] = 1'b0;
    repeat (3) begin
      step();
      chk("t4_r0_held", head[0], 0);
    end
    gate[2] = 1'b1;
    run_until_done(50);
    chk("t4_beats", out_n, 5);
    for (int i = 0; i < 4; i++) chk("t4_src2", out_src[i], 2);
    chk("t4_src0", out_src[4], 0);

    // Oversize beat saturates and sets the sticky error.
    do_reset();
    gate = '1;
    push_beat(3, 70, 1);
    run_until_done(50);
    chk("t5_nbv_sat", out_nbv[0], 64);
    chk("t5_src", out_src[0], 3);
    repeat (3) step();
    chk("t5_err_sticky", err_oversize, 1);

    // Reset mid-packet, then all valid: grant restarts at 0.
    gate = '1;
    push_beat(0, 1, 1);
    push_beat(1, 2, 0); push_beat(1, 3, 0); push_beat(1, 4, 1);
    guard = 0;
    while (head[1] == 0 && guard < 20) begin step(); guard++; end
    chk("t6_mid_packet", head[1], 1);
    do_reset();
    gate = '1;
    for (int r = 0; r < NR; r++) push_beat(r, 16, 1);
    run_until_done(50);
    chk("t6_beats", out_n, 4);
    chk("t6_g0", out_src[0], 0);
    chk("t6_g1", out_src[1], 1);
    chk("t6_pkt_count", pkt_count, 4);

    // Randomized traffic with a mid-run reset.
    do_reset();
    gate_rand = 1; mr_rand = 1;
    for (int t = 0; t < 1600; t++) begin
      if (t == 800) begin
        gate_rand = 0;
        do_reset();
        gate_rand = 1;
      end
      for (int r = 0; r < NR; r++) begin
        if (tail[r] - head[r] < 8 && $urandom_range(0, 9) == 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++)
            push_beat(r, $urandom_range(0, 72), b == len - 1);
        end
      end
      step();
    end
    gate_rand = 0; gate = '1; mr_rand = 0; mr_level = 1;
    run_until_done(500);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
